// File: rtl/tm1638_frame_ctrl.sv
// Write-only TM1638 refresh sequencer: snapshots display data on start and shifts
// one frame (data command, address + 16 bytes, display control) onto STB/CLK/DIO.
module tm1638_frame_ctrl #(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] seg_data,
    input  logic [7:0]  led_data,
    input  logic [2:0]  brightness,
    input  logic        display_on,
    output logic        busy,
    output logic        done,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio,
    output logic [2:0]  dbg_state
);

    localparam int CNT_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_BIT_LO = 3'd2,
        S_BIT_HI = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_cnt, bit_d;
    logic [4:0]       byte_cnt, byte_d;
    logic [1:0]       pkt, pkt_d;
    logic             stb_d, clk_d, dio_d, busy_d, done_d, load;

    logic [63:0] seg_q;
    logic [7:0]  led_q;
    logic [2:0]  bri_q;
    logic        on_q;

    logic [7:0] cur_byte, nxt_byte;
    logic [4:0] last_idx;

    // P1 index 0 is the address command; odd data slots are segment bytes, even are LEDs.
    function automatic logic [7:0] pkt_byte(input logic [1:0] p, input logic [4:0] idx,
                                            input logic [63:0] seg, input logic [7:0] led,
                                            input logic [2:0] bri, input logic on);
        logic [3:0] k;
        k = 4'(idx - 5'd1);
        case (p)
            2'd0:    pkt_byte = 8'h40;
            2'd1: begin
                if (idx == 5'd0)  pkt_byte = 8'hC0;
                else if (k[0])    pkt_byte = {7'b0, led[k[3:1]]};
                else              pkt_byte = seg[{k[3:1], 3'b000} +: 8];
            end
            default: pkt_byte = {4'b1000, on, bri};
        endcase
    endfunction

    assign cur_byte  = pkt_byte(pkt, byte_cnt, seg_q, led_q, bri_q, on_q);
    assign nxt_byte  = pkt_byte(pkt, byte_cnt + 5'd1, seg_q, led_q, bri_q, on_q);
    assign last_idx  = (pkt == 2'd1) ? 5'd16 : 5'd0;
    assign dbg_state = state;

    always_comb begin
        state_d = state;
        cnt_d   = cnt + CNT_W'(1);
        bit_d   = bit_cnt;
        byte_d  = byte_cnt;
        pkt_d   = pkt;
        stb_d   = tm_stb;
        clk_d   = tm_clk;
        dio_d   = tm_dio;
        busy_d  = busy;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_SETUP;
                    load    = 1'b1;
                    pkt_d   = 2'd0;
                    byte_d  = 5'd0;
                    bit_d   = 3'd0;
                    stb_d   = 1'b0;
                    clk_d   = 1'b1;
                    dio_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt == HALF_LAST) begin
                    state_d = S_BIT_LO;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    dio_d   = cur_byte[bit_cnt];
                end
            end
            S_BIT_LO: begin
                if (cnt == HALF_LAST) begin
                    state_d = S_BIT_HI;
                    cnt_d   = '0;
                    clk_d   = 1'b1;
                end
            end
            S_BIT_HI: begin
                if (cnt == HALF_LAST) begin
                    cnt_d = '0;
                    if (bit_cnt != 3'd7) begin
                        state_d = S_BIT_LO;
                        bit_d   = bit_cnt + 3'd1;
                        clk_d   = 1'b0;
                        dio_d   = cur_byte[bit_cnt + 3'd1];
                    end else begin
                        bit_d = 3'd0;
                        if (byte_cnt != last_idx) begin
                            state_d = S_BIT_LO;
                            byte_d  = byte_cnt + 5'd1;
                            clk_d   = 1'b0;
                            dio_d   = nxt_byte[0];
                        end else if (pkt == 2'd2) begin
                            state_d = S_DONE;
                            stb_d   = 1'b1;
                            dio_d   = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            stb_d   = 1'b1;
                            dio_d   = 1'b1;
                            pkt_d   = pkt + 2'd1;
                            byte_d  = 5'd0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    stb_d   = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                stb_d   = 1'b1;
                clk_d   = 1'b1;
                dio_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 5'd0;
            pkt      <= 2'd0;
            tm_stb   <= 1'b1;
            tm_clk   <= 1'b1;
            tm_dio   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            seg_q    <= '0;
            led_q    <= '0;
            bri_q    <= '0;
            on_q     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_cnt  <= bit_d;
            byte_cnt <= byte_d;
            pkt      <= pkt_d;
            tm_stb   <= stb_d;
            tm_clk   <= clk_d;
            tm_dio   <= dio_d;
            busy     <= busy_d;
            done     <= done_d;
            if (load) begin
                seg_q <= seg_data;
                led_q <= led_data;
                bri_q <= brightness;
                on_q  <= display_on;
            end
        end
    end

endmodule

// File: tb/tb_tm1638_frame_ctrl.sv
// Bench for tm1638_frame_ctrl: a TM1638-side decoder pops expected bytes and done
// times from queues filled by the stimulus sequence.
module tb_tm1638_frame_ctrl;
  localparam int N = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] seg_data;
  logic [7:0]  led_data;
  logic [2:0]  brightness;
  logic        display_on;
  logic        busy;
  logic        done;
  logic        tm_stb;
  logic        tm_clk;
  logic        tm_dio;
  logic [2:0]  dbg_state;

  tm1638_frame_ctrl #(.CLK_DIV(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seg_data(seg_data),
    .led_data(led_data), .brightness(brightness), .display_on(display_on),
    .busy(busy), .done(done), .tm_stb(tm_stb), .tm_clk(tm_clk),
    .tm_dio(tm_dio), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: {first byte of packet, byte}
  logic [8:0] exp_q[$];
  int         exp_done_q[$];
  int         errors = 0;
  int         checks = 0;

  logic       mon_en = 1'b0;
  logic       prev_stb = 1'b1;
  logic       prev_clk = 1'b1;
  logic       first_in_pkt = 1'b0;
  logic [7:0] sh = 8'h00;
  int         nbits = 0;
  int         incomplete = 0;
  int         hi_run = 0;
  int         last_gap = 0;

  logic [7:0] p1_tbl[16] = '{8'h07, 8'h01, 8'h7D, 8'h00, 8'h6D, 8'h01, 8'h66, 8'h00,
                             8'h4F, 8'h00, 8'h5B, 8'h01, 8'h06, 8'h00, 8'h07, 8'h01};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: actual=%0h required=nothing (cycle %0d)", name, act, cyc);
  endtask

  // driver tasks
  task automatic push_frame(input logic [63:0] s, input logic [7:0] l,
                            input logic [2:0] b, input logic o);
    exp_q.push_back({1'b1, 8'h40});
    exp_q.push_back({1'b1, 8'hC0});
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b0, s[8*i +: 8]});
      exp_q.push_back({1'b0, 7'b0, l[i]});
    end
    exp_q.push_back({1'b1, 4'b1000, o, b});
  endtask

  task automatic start_frame(input logic [63:0] s, input logic [7:0] l,
                             input logic [2:0] b, input logic o);
    seg_data   = s;
    led_data   = l;
    brightness = b;
    display_on = o;
    start      = 1'b1;
    exp_done_q.push_back(cyc + 1 + 311 * N);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, exp_q.size() + exp_done_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_pins(input string name);
    chk({name, "_stb"}, tm_stb, 1);
    chk({name, "_clk"}, tm_clk, 1);
    chk({name, "_dio"}, tm_dio, 1);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
  endtask

  initial begin
    int bad;
    int inc_before;
    rst_n = 1'b0; start = 1'b0; seg_data = '0; led_data = '0;
    brightness = '0; display_on = 1'b0;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (mon_en) begin
            if (tm_stb === 1'b0 && prev_stb === 1'b1) begin
              last_gap     = hi_run;
              nbits        = 0;
              first_in_pkt = 1'b1;
            end
            if (tm_stb === 1'b1 && prev_stb === 1'b0 && nbits != 0) incomplete++;
            hi_run = (tm_stb === 1'b1) ? hi_run + 1 : 0;
            if (tm_stb === 1'b0 && tm_clk === 1'b1 && prev_clk === 1'b0) begin
              sh = {tm_dio, sh[7:1]};
              nbits++;
              if (nbits == 8) begin
                if (exp_q.size() == 0) fail_unexpected("byte_unexpected", {first_in_pkt, sh});
                else chk("byte", {23'b0, first_in_pkt, sh}, {23'b0, exp_q.pop_front()});
                nbits        = 0;
                first_in_pkt = 1'b0;
              end
            end
            if (done === 1'b1) begin
              if (exp_done_q.size() == 0) fail_unexpected("done_unexpected", cyc);
              else chk("done_cycle", cyc, exp_done_q.pop_front());
              chk("busy_at_done", busy, 0);
            end
            prev_stb = tm_stb;
            prev_clk = tm_clk;
          end
        end
      end
      begin : sequence_main
        // reset values and quiet idle
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        chk_idle_pins("reset");
        bad = 0;
        for (int i = 0; i < 100; i++) begin
          @(posedge clk); #1;
          if (tm_stb !== 1'b1 || tm_clk !== 1'b1 || tm_dio !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            bad++;
        end
        chk("idle_activity", bad, 0);

        // full frame with hand-decoded bytes
        exp_q.push_back(9'h140);
        exp_q.push_back(9'h1C0);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, p1_tbl[i]});
        exp_q.push_back(9'h18D);
        start_frame(64'h0706_5B4F_666D_7D07, 8'hA5, 3'd5, 1'b1);
        chk("accept_busy", busy, 1);
        chk("accept_stb", tm_stb, 0);
        chk("accept_clk", tm_clk, 1);
        drain("full_frame");

        // snapshot: inputs change mid-frame
        push_frame(64'h3F06_5B4F_6671_7F6F, 8'h3C, 3'd2, 1'b1);
        start_frame(64'h3F06_5B4F_6671_7F6F, 8'h3C, 3'd2, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        seg_data = 64'h1122_3344_5566_7788; led_data = 8'hC3; brightness = 3'd7;
        drain("snapshot_a");
        push_frame(64'h1122_3344_5566_7788, 8'hC3, 3'd7, 1'b1);
        start_frame(64'h1122_3344_5566_7788, 8'hC3, 3'd7, 1'b1);
        drain("snapshot_b");

        // start while busy
        push_frame(64'hFFFF_0000_AAAA_5555, 8'h0F, 3'd1, 1'b1);
        start_frame(64'hFFFF_0000_AAAA_5555, 8'h0F, 3'd1, 1'b1);
        for (int c = 1; c <= 700; c++) begin
          start = (c == 10 || c == 300 || c == 600);
          @(posedge clk); #1;
        end
        start = 1'b0;
        drain("busy_ignore");

        // reset mid-frame during P1
        push_frame(64'h0102_0304_0506_0708, 8'hFF, 3'd4, 1'b1);
        start_frame(64'h0102_0304_0506_0708, 8'hFF, 3'd4, 1'b1);
        repeat (211) @(posedge clk);
        #1;
        inc_before = incomplete;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_idle_pins("midrst");
        exp_q.delete();
        exp_done_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_incomplete", incomplete, inc_before + 1);
        push_frame(64'h0706_5B4F_666D_7D07, 8'hA5, 3'd5, 1'b1);
        start_frame(64'h0706_5B4F_666D_7D07, 8'hA5, 3'd5, 1'b1);
        drain("after_rst");

        // back-to-back with minimum brightness, display off
        seg_data = 64'h8040_2010_0804_0201; led_data = 8'h81; brightness = 3'd0; display_on = 1'b0;
        push_frame(64'h8040_2010_0804_0201, 8'h81, 3'd0, 1'b0);
        push_frame(64'h8040_2010_0804_0201, 8'h81, 3'd0, 1'b0);
        start = 1'b1;
        exp_done_q.push_back(cyc + 1 + 311 * N);
        exp_done_q.push_back(cyc + 1 + 311 * N + 2 + 311 * N);
        repeat (630) @(posedge clk);
        #1;
        chk("b2b_gap_ge1", (last_gap >= 1), 1);
        repeat (70) @(posedge clk);
        #1;
        start = 1'b0;
        drain("b2b");
        chk_idle_pins("final");
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
